// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg : shared constants for the data-memory stage (MMIO map, halt code)
// -----------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

   // Word offsets inside the MMIO window (address[3:2])
   localparam logic [1:0] OFF_TOHOST   = 2'd0;
   localparam logic [1:0] OFF_CYCLE_LO = 2'd1;
   localparam logic [1:0] OFF_SCRATCH  = 2'd2;
   localparam logic [1:0] OFF_CYCLE_HI = 2'd3;

   // Default value of the top address nibble that selects the MMIO window
   localparam logic [3:0] MMIO_TAG_DEFAULT = 4'hF;

   // Value written to TOHOST that stops the machine
   localparam int unsigned HALT_CODE = 1;

   // An access is misaligned when either byte-offset bit is set
   function automatic logic is_misaligned(input logic [1:0] byte_off);
      return byte_off != 2'b00;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram : single-port synchronous word RAM, write-first read port
// -----------------------------------------------------------------------------
`default_nettype none

module dmem_ram #(
   parameter int    DEPTH     = 4096,
   parameter int    XLEN      = 32,
   parameter string INIT_FILE = "",
   localparam int   AW        = $clog2(DEPTH)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            re_i,
   input  logic            we_i,
   input  logic [AW-1:0]   addr_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] rdata_o
);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [XLEN-1:0] rdata_q;

   // Array write; contents are deliberately untouched by reset
   always_ff @(posedge clock) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Output register: write-first on a simultaneous read/write, holds when idle
   always_ff @(posedge clock) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (re_i && we_i) begin
         rdata_q <= wdata_i;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem.sv
// -----------------------------------------------------------------------------
// dmem : data-memory stage behind the CPU MEM stage. Word RAM plus an MMIO
//        window (TOHOST/halt, 64-bit cycle counter, scratch), misalign flag.
//        Zero wait states; load data registered one cycle after the request.
// -----------------------------------------------------------------------------
`default_nettype none

module dmem
   import dmem_pkg::*;
#(
   parameter int         XLEN      = 32,
   parameter int         DEPTH     = 4096,
   parameter logic [3:0] MMIO_TAG  = MMIO_TAG_DEFAULT,
   parameter string      INIT_FILE = ""
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            mem_load,
   input  logic            mem_store,
   input  logic [XLEN-1:0] address,
   input  logic [XLEN-1:0] store_data,
   output logic [XLEN-1:0] load_data,
   output logic [XLEN-1:0] tohost,
   output logic            tohost_valid,
   output logic            halt,
   output logic            misalign_err
);

   localparam int AW = $clog2(DEPTH);

   // Decode
   logic            mmio_sel;
   logic            mmio_in_range;
   logic [1:0]      mmio_off;
   logic            store_ok;
   logic            ram_we;
   logic            ram_re;
   logic            tohost_wr;
   logic            scratch_wr;
   logic [XLEN-1:0] ram_rdata;
   logic [XLEN-1:0] mmio_rdata_d;

   // State
   logic [63:0]     cycle_q;
   logic [XLEN-1:0] tohost_q;
   logic [XLEN-1:0] scratch_q;
   logic            tohost_valid_q;
   logic            halt_q;
   logic            misalign_q;
   logic            rd_mmio_q;
   logic [XLEN-1:0] mmio_rdata_q;

   assign mmio_sel      = (address[XLEN-1 -: 4] == MMIO_TAG);
   assign mmio_in_range = (address[XLEN-5:4] == '0);
   assign mmio_off      = address[3:2];

   // A store lands only outside reset and before halt; everything keys off this
   assign store_ok   = mem_store & reset & ~halt_q;
   assign ram_we     = store_ok & ~mmio_sel;
   assign ram_re     = mem_load & ~mmio_sel;
   assign tohost_wr  = store_ok & mmio_sel & mmio_in_range & (mmio_off == OFF_TOHOST);
   assign scratch_wr = store_ok & mmio_sel & mmio_in_range & (mmio_off == OFF_SCRATCH);

   // MMIO read mux; a concurrent accepted store wins (write-first)
   always_comb begin
      mmio_rdata_d = '0;
      if (store_ok) begin
         mmio_rdata_d = store_data;
      end else if (mmio_in_range) begin
         case (mmio_off)
            OFF_TOHOST:   mmio_rdata_d = tohost_q;
            OFF_CYCLE_LO: mmio_rdata_d = XLEN'(cycle_q[31:0]);
            OFF_SCRATCH:  mmio_rdata_d = scratch_q;
            OFF_CYCLE_HI: mmio_rdata_d = XLEN'(cycle_q[63:32]);
            default:      mmio_rdata_d = '0;
         endcase
      end
   end

   dmem_ram #(
      .DEPTH     (DEPTH),
      .XLEN      (XLEN),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clock   (clock),
      .reset   (reset),
      .re_i    (ram_re),
      .we_i    (ram_we),
      .addr_i  (address[AW+1:2]),
      .wdata_i (store_data),
      .rdata_o (ram_rdata)
   );

   // MMIO registers, free-running counter, sticky flags and MMIO read capture
   always_ff @(posedge clock) begin
      if (!reset) begin
         cycle_q        <= '0;
         tohost_q       <= '0;
         scratch_q      <= '0;
         tohost_valid_q <= 1'b0;
         halt_q         <= 1'b0;
         misalign_q     <= 1'b0;
         rd_mmio_q      <= 1'b0;
         mmio_rdata_q   <= '0;
      end else begin
         cycle_q        <= cycle_q + 64'd1;
         tohost_valid_q <= tohost_wr;
         if (tohost_wr) begin
            tohost_q <= store_data;
            if (store_data == XLEN'(HALT_CODE)) begin
               halt_q <= 1'b1;
            end
         end
         if (scratch_wr) begin
            scratch_q <= store_data;
         end
         if ((mem_load || mem_store) && is_misaligned(address[1:0])) begin
            misalign_q <= 1'b1;
         end
         // Remember which source the last load came from so idle cycles hold it
         if (mem_load) begin
            rd_mmio_q <= mmio_sel;
            if (mmio_sel) begin
               mmio_rdata_q <= mmio_rdata_d;
            end
         end
      end
   end

   assign load_data    = rd_mmio_q ? mmio_rdata_q : ram_rdata;
   assign tohost       = tohost_q;
   assign tohost_valid = tohost_valid_q;
   assign halt         = halt_q;
   assign misalign_err = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem.sv
// -----------------------------------------------------------------------------
// tb_dmem : self-checking bench for dmem; load expectations go through a queue
// -----------------------------------------------------------------------------
`default_nettype none

module tb_dmem;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        mem_load = 1'b0;
   logic        mem_store = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] store_data = '0;
   logic [31:0] load_data;
   logic [31:0] tohost;
   logic        tohost_valid;
   logic        halt;
   logic        misalign_err;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] sb[$];
   logic [31:0] exp;

   dmem #(
      .XLEN      (32),
      .DEPTH     (4096),
      .MMIO_TAG  (4'hF),
      .INIT_FILE ("")
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .mem_load     (mem_load),
      .mem_store    (mem_store),
      .address      (address),
      .store_data   (store_data),
      .load_data    (load_data),
      .tohost       (tohost),
      .tohost_valid (tohost_valid),
      .halt         (halt),
      .misalign_err (misalign_err)
   );

   always #5 clock = ~clock;

   // Present one request for one rising edge; returns at the following negedge
   task automatic cyc(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] d);
      mem_load   = ld;
      mem_store  = st;
      address    = a;
      store_data = d;
      @(negedge clock);
      mem_load   = 1'b0;
      mem_store  = 1'b0;
   endtask

   // Load request with its expected result queued; compared once the data appears
   task automatic load_chk(input logic [31:0] a, input logic [31:0] e, input string nm);
      sb.push_back(e);
      cyc(1'b1, 1'b0, a, '0);
      exp = sb.pop_front();
      checks++;
      if (load_data !== exp) begin
         errors++;
         $display("FAIL %s: load_data=%h expected=%h", nm, load_data, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cyc(1'b0, 1'b0, '0, '0);
      cyc(1'b0, 1'b0, '0, '0);
      reset = 1'b1;
      checks++;
      if ({load_data, tohost, tohost_valid, halt, misalign_err} !== 67'd0) begin
         errors++;
         $display("FAIL reset_state: ld=%h th=%h v=%b h=%b m=%b expected all zero",
                  load_data, tohost, tohost_valid, halt, misalign_err);
      end
   endtask

   task automatic test_store_load();
      cyc(1'b0, 1'b1, 32'h100, 32'hDEADBEEF);
      load_chk(32'h100, 32'hDEADBEEF, "store_then_load");
      checks++;
      if (misalign_err !== 1'b0) begin
         errors++;
         $display("FAIL misalign_aligned: got=%b expected=0", misalign_err);
      end
      // Idle cycle: load_data must hold
      cyc(1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (load_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL hold: load_data=%h expected=deadbeef", load_data);
      end
   endtask

   task automatic test_wrap();
      cyc(1'b0, 1'b1, 32'h0000_4004, 32'h11);
      load_chk(32'h0000_0004, 32'h11, "addr_wrap");
   endtask

   task automatic test_misalign();
      load_chk(32'h102, 32'hDEADBEEF, "misaligned_load_data");
      checks++;
      if (misalign_err !== 1'b1) begin
         errors++;
         $display("FAIL misalign_set: got=%b expected=1", misalign_err);
      end
      for (int i = 0; i < 10; i++) begin
         load_chk(32'h100, 32'hDEADBEEF, "aligned_after_misalign");
         checks++;
         if (misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_sticky: iter=%0d got=%b expected=1", i, misalign_err);
         end
      end
      reset = 1'b0;
      cyc(1'b0, 1'b0, '0, '0);
      reset = 1'b1;
      checks++;
      if (misalign_err !== 1'b0) begin
         errors++;
         $display("FAIL misalign_clear: got=%b expected=0", misalign_err);
      end
   endtask

   task automatic test_cycle();
      reset = 1'b0;
      cyc(1'b0, 1'b0, '0, '0);
      reset = 1'b1;
      repeat (20) cyc(1'b0, 1'b0, '0, '0);
      load_chk(32'hF000_0004, 32'd20, "cycle_lo");
      load_chk(32'hF000_000C, 32'd0, "cycle_hi");
      load_chk(32'hF000_0010, 32'd0, "mmio_out_of_range");
   endtask

   task automatic test_tohost_halt();
      cyc(1'b0, 1'b1, 32'h200, 32'hA5);
      cyc(1'b0, 1'b1, 32'hF000_0008, 32'h33);
      load_chk(32'hF000_0008, 32'h33, "scratch_rw");
      cyc(1'b0, 1'b1, 32'hF000_0000, 32'h42);
      checks++;
      if (tohost !== 32'h42 || tohost_valid !== 1'b1 || halt !== 1'b0) begin
         errors++;
         $display("FAIL tohost_write: th=%h v=%b h=%b expected 42/1/0", tohost, tohost_valid, halt);
      end
      cyc(1'b0, 1'b0, '0, '0);
      checks++;
      if (tohost_valid !== 1'b0) begin
         errors++;
         $display("FAIL tohost_pulse_len: v=%b expected=0", tohost_valid);
      end
      load_chk(32'hF000_0000, 32'h42, "tohost_read");
      cyc(1'b0, 1'b1, 32'hF000_0000, 32'h1);
      checks++;
      if (halt !== 1'b1 || tohost !== 32'h1) begin
         errors++;
         $display("FAIL halt_set: h=%b th=%h expected 1/00000001", halt, tohost);
      end
      cyc(1'b0, 1'b1, 32'h200, 32'h55);
      cyc(1'b0, 1'b1, 32'hF000_0008, 32'h7);
      cyc(1'b0, 1'b1, 32'hF000_0000, 32'h99);
      checks++;
      if (tohost !== 32'h1 || tohost_valid !== 1'b0) begin
         errors++;
         $display("FAIL tohost_after_halt: th=%h v=%b expected 00000001/0", tohost, tohost_valid);
      end
      load_chk(32'h200, 32'hA5, "ram_store_dropped");
      load_chk(32'hF000_0008, 32'h33, "scratch_store_dropped");
   endtask

   task automatic test_back_to_back();
      reset = 1'b0;
      cyc(1'b0, 1'b0, '0, '0);
      reset = 1'b1;
      cyc(1'b0, 1'b1, 32'h300, 32'h1234);
      // Simultaneous load and store returns the stored word
      sb.push_back(32'h77);
      cyc(1'b1, 1'b1, 32'h400, 32'h77);
      exp = sb.pop_front();
      checks++;
      if (load_data !== exp) begin
         errors++;
         $display("FAIL load_store_same_cycle: load_data=%h expected=%h", load_data, exp);
      end
      load_chk(32'h400, 32'h77, "after_simultaneous");
      load_chk(32'h301, 32'h1234, "misaligned_0x301");
      cyc(1'b0, 1'b1, 32'hF000_0000, 32'h5);
      // Reset asserted with a store pending: store dropped, outputs cleared
      reset = 1'b0;
      cyc(1'b0, 1'b1, 32'h300, 32'hBAD);
      reset = 1'b1;
      checks++;
      if ({load_data, tohost, tohost_valid, halt, misalign_err} !== 67'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: ld=%h th=%h v=%b h=%b m=%b expected all zero",
                  load_data, tohost, tohost_valid, halt, misalign_err);
      end
      load_chk(32'h300, 32'h1234, "store_in_reset_dropped");
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_wrap();
      test_misalign();
      test_cycle();
      test_tohost_halt();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
